// File: rtl/tone_sequencer.sv
// tone_sequencer: manual/song control of the clk_divider frequency word and tone gate
module tone_sequencer #(
  parameter int unsigned NOTE_TICKS = 12_500_000,
  parameter int unsigned GAP_TICKS = 1_000_000,
  parameter int unsigned SONG_LEN = 8
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic [2:0]  sw_note,
  input  logic        manual_en,
  input  logic        start,
  output logic [31:0] freq_out,
  output logic        tone_en,
  output logic        busy,
  output logic        done,
  output logic [2:0]  note_idx
);
  typedef enum logic [2:0] {IDLE, MANUAL, PLAY, GAP, DONE} state_t;
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_TICKS - 1);
  localparam logic [2:0] IDX_LAST = 3'(SONG_LEN - 1);
  state_t r_state;
  logic [31:0] r_cnt;
  logic [2:0] w_next_idx;
  logic w_note_end, w_gap_end, w_last_step;
  function automatic logic [31:0] note_hz(input logic [2:0] c);
    case (c)
      3'd0: note_hz = 32'd523;
      3'd1: note_hz = 32'd587;
      3'd2: note_hz = 32'd659;
      3'd3: note_hz = 32'd698;
      3'd4: note_hz = 32'd783;
      3'd5: note_hz = 32'd880;
      3'd6: note_hz = 32'd987;
      default: note_hz = 32'd1046;
    endcase
  endfunction
  always_comb begin
    w_next_idx = note_idx + 3'd1;
    w_note_end = r_cnt == NOTE_LAST;
    w_gap_end = r_cnt == GAP_LAST;
    w_last_step = note_idx == IDX_LAST;
  end
  // outputs are loaded on the transition edge so each state's values appear in its first cycle
  always_ff @(posedge in_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      freq_out <= '0;
      tone_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      note_idx <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= PLAY;
            r_cnt <= '0;
            note_idx <= '0;
            freq_out <= note_hz(3'd0);
            tone_en <= 1'b1;
            busy <= 1'b1;
          end else if (manual_en) begin
            r_state <= MANUAL;
            freq_out <= note_hz(sw_note);
            tone_en <= 1'b1;
          end
        end
        MANUAL: begin
          if (!manual_en) begin
            r_state <= IDLE;
            freq_out <= '0;
            tone_en <= 1'b0;
          end else begin
            freq_out <= note_hz(sw_note);
          end
        end
        PLAY: begin
          if (w_note_end) begin
            r_state <= GAP;
            r_cnt <= '0;
            tone_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        GAP: begin
          if (!w_gap_end) begin
            r_cnt <= r_cnt + 32'd1;
          end else if (w_last_step) begin
            r_state <= DONE;
            r_cnt <= '0;
            done <= 1'b1;
            busy <= 1'b0;
            freq_out <= '0;
          end else begin
            r_state <= PLAY;
            r_cnt <= '0;
            note_idx <= w_next_idx;
            freq_out <= note_hz(w_next_idx);
            tone_en <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          note_idx <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt <= '0;
          freq_out <= '0;
          tone_en <= 1'b0;
          busy <= 1'b0;
          note_idx <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench for two sequencer configurations (4/2/8 and 1/1/1)
module tb_tone_sequencer;
  typedef struct {
    logic [31:0] f;
    bit t;
    bit b;
    bit dn;
    int idx;
  } exp_t;
  logic clk = 1'b0;
  logic s_rst[2], s_start[2], s_man[2];
  logic [2:0] s_sw[2];
  logic [31:0] fo[2];
  logic te[2], bz[2], dn[2];
  logic [2:0] ni[2];
  int nt[2] = '{4, 1};
  int gt[2] = '{2, 1};
  int sl[2] = '{8, 1};
  int tbl[8] = '{523, 587, 659, 698, 783, 880, 987, 1046};
  exp_t sb[2][$];
  exp_t plan[2][$];
  bit man_mode[2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  tone_sequencer #(.NOTE_TICKS(4), .GAP_TICKS(2), .SONG_LEN(8)) u_a (
    .in_clk(clk), .reset(s_rst[0]), .sw_note(s_sw[0]), .manual_en(s_man[0]), .start(s_start[0]),
    .freq_out(fo[0]), .tone_en(te[0]), .busy(bz[0]), .done(dn[0]), .note_idx(ni[0]));
  tone_sequencer #(.NOTE_TICKS(1), .GAP_TICKS(1), .SONG_LEN(1)) u_b (
    .in_clk(clk), .reset(s_rst[1]), .sw_note(s_sw[1]), .manual_en(s_man[1]), .start(s_start[1]),
    .freq_out(fo[1]), .tone_en(te[1]), .busy(bz[1]), .done(dn[1]), .note_idx(ni[1]));
  function automatic exp_t mk(int f, bit t, bit b, bit d, int idx);
    exp_t e;
    e.f = 32'(f);
    e.t = t;
    e.b = b;
    e.dn = d;
    e.idx = idx;
    return e;
  endfunction
  // whole song timeline: notes and gaps, the done pulse, then the forced idle cycle
  task automatic build_song(int d);
    for (int k = 0; k < sl[d]; k++) begin
      repeat (nt[d]) plan[d].push_back(mk(tbl[k], 1, 1, 0, k));
      repeat (gt[d]) plan[d].push_back(mk(tbl[k], 0, 1, 0, k));
    end
    plan[d].push_back(mk(0, 0, 0, 1, -1));
    plan[d].push_back(mk(0, 0, 0, 0, 0));
  endtask
  task automatic model(int d);
    exp_t e;
    if (s_rst[d]) begin
      plan[d].delete();
      man_mode[d] = 0;
      e = mk(0, 0, 0, 0, 0);
    end else if (plan[d].size() > 0) begin
      e = plan[d].pop_front();
    end else if (man_mode[d]) begin
      man_mode[d] = s_man[d];
      e = s_man[d] ? mk(tbl[s_sw[d]], 1, 0, 0, 0) : mk(0, 0, 0, 0, 0);
    end else if (s_start[d]) begin
      build_song(d);
      e = plan[d].pop_front();
    end else if (s_man[d]) begin
      man_mode[d] = 1;
      e = mk(tbl[s_sw[d]], 1, 0, 0, 0);
    end else begin
      e = mk(0, 0, 0, 0, 0);
    end
    sb[d].push_back(e);
  endtask
  task automatic step();
    for (int d = 0; d < 2; d++) model(d);
    @(posedge clk);
    #1;
    cyc++;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (sb[d].size() > 0) begin
          e = sb[d].pop_front();
          checks++;
          if (fo[d] !== e.f || te[d] !== e.t || bz[d] !== e.b || dn[d] !== e.dn ||
              (e.idx >= 0 && ni[d] !== 3'(e.idx))) begin
            errors++;
            $display("FAIL dut%0d cyc%0d: got freq=%0d tone=%0b busy=%0b done=%0b idx=%0d want freq=%0d tone=%0b busy=%0b done=%0b idx=%0d",
                     d, cyc, fo[d], te[d], bz[d], dn[d], ni[d], e.f, e.t, e.b, e.dn, e.idx);
          end
        end
      end
    end
  end
  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      s_start[d] = 0;
      s_man[d] = 0;
      s_rst[d] = 0;
    end
  endtask
  initial begin : stim
    int n;
    for (int d = 0; d < 2; d++) begin
      s_rst[d] = 1;
      s_start[d] = 0;
      s_man[d] = 0;
      s_sw[d] = 3'd0;
      man_mode[d] = 0;
    end
    repeat (3) step();
    idle_all();
    repeat (2) step();
    s_man[0] = 1;
    for (int k = 0; k < 8; k++) begin
      s_sw[0] = 3'(k);
      step();
    end
    repeat (10) begin
      s_sw[0] = 3'($urandom_range(0, 7));
      s_start[0] = 1'($urandom_range(0, 1));
      step();
    end
    idle_all();
    repeat (2) step();
    s_start[0] = 1;
    step();
    s_start[0] = 0;
    repeat (55) begin
      s_start[0] = ($urandom_range(0, 3) == 0);
      s_man[0] = 1'($urandom_range(0, 1));
      step();
    end
    idle_all();
    repeat (3) step();
    s_man[0] = 1;
    s_start[0] = 1;
    step();
    s_start[0] = 0;
    repeat (52) begin
      s_sw[0] = 3'($urandom_range(0, 7));
      step();
    end
    idle_all();
    repeat (2) step();
    s_start[0] = 1;
    step();
    s_start[0] = 0;
    repeat (19) step();
    s_rst[0] = 1;
    step();
    s_rst[0] = 0;
    step();
    s_start[0] = 1;
    step();
    s_start[0] = 0;
    repeat (51) step();
    s_start[1] = 1;
    step();
    s_start[1] = 0;
    repeat (5) step();
    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        s_rst[d] = ($urandom_range(0, 99) == 0);
        s_start[d] = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 7) == 0) s_man[d] = ~s_man[d];
        s_sw[d] = 3'($urandom_range(0, 7));
      end
      step();
    end
    idle_all();
    n = 0;
    while ((plan[0].size() > 0 || plan[1].size() > 0 || man_mode[0] || man_mode[1]) && n < 200) begin
      step();
      n++;
    end
    step();
    @(negedge clk);
    #1;
    checks++;
    if (sb[0].size() + sb[1].size() != 0 || n >= 200) begin
      errors++;
      $display("FAIL drain: pending=%0d cycles=%0d, want pending=0 cycles<200", sb[0].size() + sb[1].size(), n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Control block for the tone organ's `clk_divider`. It drives the divider's 32-bit `freq_in` word and a tone-enable gate, and has two modes:
- **Manual:** a 3-bit switch value selects one of eight scale notes.
- **Song:** an internal 8-step note sequence plays with fixed note and gap durations.

It sits between the board switches/keys and `clk_divider`, on the same system clock.

## Interface
Parameters:
- `NOTE_TICKS`, default 12_500_000: clock cycles each note sounds in song mode (≥1).
- `GAP_TICKS`, default 1_000_000: silent cycles after each song note (≥1).
- `SONG_LEN`, default 8: number of song steps (1..8).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `in_clk`  in  1  system clock.
  - `reset`  in  1  synchronous, active-high reset.
- `sw_note`  in  3  manual note select: 0=Do … 7=Do'.
- `manual_en`  in  1  level; holds manual mode while high.
- `start`  in  1  single-cycle pulse; begins song playback from IDLE.
- `freq_out`  out  32  frequency word to `clk_divider.freq_in` (Hz).
- `tone_en`  out  1  high while a note should sound.
- `busy`  out  1  high in PLAY and GAP.
- `done`  out  1  one-cycle pulse when a song completes.
- `note_idx`  out  3  current song step (0..SONG_LEN-1).

## Operation
- **Note table** (combinational ROM, code→Hz): 0→523, 1→587, 2→659, 3→698, 4→783, 5→880, 6→987, 7→1046.
- **Song step** k plays note code k (ascending scale), for k = 0..SONG_LEN-1.
- **FSM states:** IDLE, MANUAL, PLAY, GAP, DONE. All outputs are registered.
- **IDLE:**
  - Outputs: `freq_out`=0, `tone_en`=0, `busy`=0, `note_idx`=0.
  - `start`=1 → PLAY; counter cleared, `note_idx`=0.
  - Else `manual_en`=1 → MANUAL.
  - If `start` and `manual_en` are high together, `start` wins.
- **MANUAL:**
  - `freq_out` = table[`sw_note`], updated every cycle; `tone_en`=1.
  - `manual_en`=0 → IDLE.
  - `start` is ignored.
- **PLAY:**
  - `freq_out` = table[`note_idx`], `tone_en`=1, `busy`=1.
  - 32-bit tick counter counts 0..NOTE_TICKS-1.
  - On the terminal count → GAP; counter cleared.
- **GAP:**
  - `tone_en`=0, `freq_out` holds the last note, `busy`=1.
  - Counts 0..GAP_TICKS-1. On the terminal count:
    - `note_idx`==SONG_LEN-1 → DONE.
    - Otherwise `note_idx`+1 → PLAY; counter cleared.
- **DONE:**
  - `done`=1 for exactly one cycle; `busy`=0, `tone_en`=0, `freq_out`=0.
  - Next state IDLE, `note_idx`=0.
- **Ignored inputs while busy:**
  - `start` during PLAY/GAP/DONE is ignored; there is no restart or queueing.
  - `manual_en` is ignored until the FSM reaches IDLE.
- **Counter and index width:**
  - Counter compare uses 32-bit unsigned arithmetic; the counter never wraps.
  - `note_idx` never exceeds SONG_LEN-1.
- **Reset:** asserted in any state, including mid-note, it forces IDLE at the next edge with all outputs 0.

## Timing
- **Song start:** `start` is sampled at edge N in IDLE. From edge N+1: state PLAY, `tone_en`=1, `freq_out`=523, `busy`=1.
- **Durations:**
  - Each PLAY interval lasts exactly NOTE_TICKS cycles.
  - Each GAP interval lasts exactly GAP_TICKS cycles.
- **Done pulse:** `done` asserts exactly SONG_LEN×(NOTE_TICKS+GAP_TICKS) cycles after the first PLAY cycle. It lasts 1 cycle, and IDLE follows.
- **Manual mode:**
  - Latency from a `sw_note` or `manual_en` change to `freq_out`/`tone_en` is 1 cycle.
  - Releasing `manual_en` → `tone_en`=0 and `freq_out`=0 one cycle later.
- **Reset latency:** the reset response takes 1 cycle; the first post-reset cycle is IDLE.

## Test plan
Directed scenarios:
1. **Reset values:** reset high 3 cycles, then low. Required: `freq_out`=0, `tone_en`=0, `busy`=0, `done`=0, `note_idx`=0.
2. **Manual mode:** `manual_en`=1 with `sw_note` stepping 0→7. Required: `freq_out` follows 523…1046 one cycle behind and `tone_en`=1. Then `manual_en`=0 → `freq_out`=0 next cycle.
3. **Full song:** NOTE_TICKS=4, GAP_TICKS=2, SONG_LEN=8, pulse `start`. Required:
   - `tone_en` is high 4 / low 2 cycles, repeated ×8.
   - `freq_out` runs 523,587,…,1046.
   - `done` pulses exactly 48 cycles after the first PLAY cycle.
4. **Start conflicts:**
   - `start` re-pulsed during PLAY and GAP → ignored, and `done` timing is unchanged.
   - `start` and `manual_en` high together in IDLE → song mode is entered.
5. **Reset mid-operation:** reset asserted mid-PLAY at step 3. Required: next cycle IDLE with all outputs 0; a subsequent `start` restarts at 523.
6. **Single-step song:** SONG_LEN=1, NOTE_TICKS=1, GAP_TICKS=1. Required: 1 cycle `tone_en` at 523, 1 gap cycle, then `done`, then IDLE.
